uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
Framed command decoder downstream of uart_rx_path and upstream of uart_tx_path, in the clk_50m domain. It consumes received bytes, validates fixed 4-byte frames, and executes LED commands on a 6-bit LED register. It returns one response byte per frame to the TX path. It replaces the ad-hoc per-byte LED toggling in the top level.

Parameters:
HDR_BYTE, 8'hA5, frame header byte.
ACK_BYTE, 8'h5A, response for successful write/toggle.
NAK_BYTE, 8'hEE, response for rejected frame.
TIMEOUT_CYC, 2_500_000, inter-byte timeout in clk_50m cycles (50 ms); used only when the optional feature is compiled in.

Ports:
clk_50m  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
rx_data  input  8  byte from uart_rx_path, valid while rx_done high
rx_done  input  1  byte-received strobe from uart_rx_path; level of any length, and its rising edge is the event
tx_busy  input  1  high while uart_tx_path is shifting a byte
tx_data  output  8  response byte, stable from tx_start until tx_busy falls
tx_start  output  1  one-cycle pulse requesting transmission of tx_data
led  output  6  LED register
frame_ok_cnt  output  8  count of accepted frames, wraps 255->0
frame_err_cnt  output  8  count of rejected or aborted frames, saturates at 255

Behaviour:
- Reset: state=S_HDR, led=6'h00, tx_data=8'h00, tx_start=0, both counters=0, rx_done edge register=0, timeout counter=0.
- Byte event: rx_ev = rx_done & ~rx_done_q, with rx_done_q registered. rx_data is sampled on the rx_ev cycle.
- Frame format: HDR_BYTE, CMD, ARG, SUM, where SUM = CMD ^ ARG.
- S_HDR:
  - rx_ev with HDR_BYTE -> S_CMD.
  - Any other byte is discarded. State stays S_HDR and no counter changes.
- S_CMD: rx_ev -> latch CMD -> S_ARG.
- S_ARG: rx_ev -> latch ARG -> S_SUM.
- S_SUM: rx_ev -> latch SUM -> S_EXEC.
- S_EXEC (single cycle): evaluates the frame in this priority order.
  1. SUM mismatch -> NAK.
  2. CMD 8'h01 (toggle): ARG<=5 -> led[ARG] inverts, ACK. ARG>5 -> NAK.
  3. CMD 8'h02 (write): led <= ARG[5:0], ACK. ARG[7:6] are ignored.
  4. CMD 8'h03 (read): response byte = {2'b00, led}. led is unchanged.
  5. Any other CMD -> NAK.
- S_EXEC updates: response byte is loaded into tx_data. ACK/read increments frame_ok_cnt; NAK increments frame_err_cnt. Next state is S_RESP.
- Latency: led changes on the clock edge one cycle after the SUM rx_ev cycle.
- S_RESP:
  - Waits for tx_busy=0, then pulses tx_start for one cycle -> S_HDR.
  - With tx_busy=0 on entry, tx_start rises two cycles after the SUM rx_ev cycle.
  - rx_ev in S_EXEC/S_RESP: byte is dropped and frame_err_cnt increments. Parsing resumes at S_HDR only.
- tx_start is never asserted while tx_busy=1. tx_data is held until the next S_EXEC.
- Reset asserted mid-frame or mid-response: immediate return to reset values. A partial frame is discarded and not counted.
- Simultaneous reset and rx_ev: reset wins.

Optional Feature:
UART_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_ev and increments while in S_CMD, S_ARG or S_SUM.
  - When it reaches TIMEOUT_CYC-1: state -> S_HDR, frame_err_cnt increments, no response is sent.
  - A timeout and an rx_ev in the same cycle: the rx_ev wins and the frame continues.
- Undefined: no counter logic is present; the parser waits indefinitely between bytes.

Test Plan:
- Reset, then frame A5 02 2A 28 -> led=6'h2A, tx_data=8'h5A, one tx_start pulse two cycles after the SUM event, frame_ok_cnt=1.
- From led=6'h2A, frame A5 01 00 01 then A5 03 00 03 -> led=6'h2B, responses 5A then 2B, frame_ok_cnt=2 more.
- Frame A5 01 06 07 (bit out of range) and frame A5 02 11 00 (bad SUM) -> led unchanged, two NAK (8'hEE) responses, frame_err_cnt=2.
- Garbage 00 FF 13 then A5 02 3F 3D -> led=6'h3F, garbage not counted. Hold tx_busy=1 for 1000 cycles: tx_start waits and fires one cycle after tx_busy falls.
- rx_done held high 20 cycles per byte -> each byte counted once. Assert reset after A5 02 -> led=0, counters=0, no tx_start.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYC=100: send A5 02, idle 100 cycles -> state S_HDR, frame_err_cnt=1, no tx_start. Then A5 02 01 03 -> led=6'h01.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Framed LED command decoder between uart_rx_path and uart_tx_path (clk_50m domain).
//   A frame is HDR_BYTE, CMD, ARG, SUM with SUM = CMD ^ ARG. Every complete frame is
//   answered with exactly one response byte: ACK_BYTE, NAK_BYTE or, for a read, {2'b00, led}.
//   Commands: 8'h01 toggle led[ARG] (ARG <= 5), 8'h02 write led <= ARG[5:0], 8'h03 read.
//
//   Optional build macro UART_CMD_TIMEOUT_EN: abandons a partial frame after TIMEOUT_CYC
//   idle cycles between bytes, counting it as an error and sending no response. Without
//   the macro the parser waits indefinitely between bytes.
//
// Ports
//   clk_50m        in   system clock, 50 MHz
//   reset          in   asynchronous, active-high reset
//   rx_data[7:0]   in   received byte, valid while rx_done is high
//   rx_done        in   byte strobe; only its rising edge is an event
//   tx_busy        in   transmitter is shifting a byte
//   tx_data[7:0]   out  response byte, held until the next frame is evaluated
//   tx_start       out  one-cycle transmit request, never issued while tx_busy is high
//   led[5:0]       out  LED register
//   frame_ok_cnt   out  accepted frames, wraps 255 -> 0
//   frame_err_cnt  out  rejected, dropped-byte or aborted frames, saturates at 255
module uart_cmd_decoder #(
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h5A,
  parameter logic [7:0]  NAK_BYTE    = 8'hEE,
  parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
  input  logic       clk_50m,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [5:0] led,
  output logic [7:0] frame_ok_cnt,
  output logic [7:0] frame_err_cnt
);

  localparam logic [7:0] CmdToggle = 8'h01;
  localparam logic [7:0] CmdWrite  = 8'h02;
  localparam logic [7:0] CmdRead   = 8'h03;

  localparam int unsigned    ToW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StHdr, StCmd, StArg, StSum, StExec, StResp} state_e;

  state_e     state_q;
  logic       rx_done_q;
  logic       rx_ev;
  logic [7:0] cmd_q, arg_q, sum_q;
  logic       timeout;

  assign rx_ev = rx_done & ~rx_done_q;

  // Frame evaluation; only consumed while in StExec.
  logic       exec_ack;
  logic [7:0] exec_resp;
  logic [5:0] exec_led;

  always_comb begin
    exec_ack  = 1'b0;
    exec_resp = NAK_BYTE;
    exec_led  = led;
    if (sum_q == (cmd_q ^ arg_q)) begin
      case (cmd_q)
        CmdToggle: begin
          if (arg_q <= 8'd5) begin
            exec_led  = led ^ (6'd1 << arg_q[2:0]);
            exec_resp = ACK_BYTE;
            exec_ack  = 1'b1;
          end
        end
        CmdWrite: begin
          exec_led  = arg_q[5:0];
          exec_resp = ACK_BYTE;
          exec_ack  = 1'b1;
        end
        CmdRead: begin
          exec_resp = {2'b00, led};
          exec_ack  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Error increments can coincide (NAK plus a byte dropped in the same cycle), so sum
  // them before saturating.
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic [7:0] err_next;

  always_comb begin
    err_inc = 2'd0;
    if (rx_ev && (state_q == StExec || state_q == StResp)) err_inc = err_inc + 2'd1;
    if (state_q == StExec && !exec_ack)                     err_inc = err_inc + 2'd1;
    if (timeout)                                            err_inc = err_inc + 2'd1;
    err_sum  = {1'b0, frame_err_cnt} + {7'd0, err_inc};
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

`ifdef UART_CMD_TIMEOUT_EN
  logic [ToW-1:0] to_cnt_q;
  logic           in_body;

  assign in_body = (state_q == StCmd) || (state_q == StArg) || (state_q == StSum);
  // A byte arriving in the expiry cycle keeps the frame alive.
  assign timeout = in_body && !rx_ev && (to_cnt_q == ToMax);

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (rx_ev || !in_body || timeout) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + ToW'(1);
    end
  end
`else
  logic unused_to_cfg;

  assign timeout       = 1'b0;
  // Timeout sizing is only meaningful when the feature is built in.
  assign unused_to_cfg = ^ToMax;
`endif

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      state_q       <= StHdr;
      rx_done_q     <= 1'b0;
      cmd_q         <= 8'h00;
      arg_q         <= 8'h00;
      sum_q         <= 8'h00;
      led           <= 6'h00;
      tx_data       <= 8'h00;
      tx_start      <= 1'b0;
      frame_ok_cnt  <= 8'h00;
      frame_err_cnt <= 8'h00;
    end else begin
      rx_done_q     <= rx_done;
      tx_start      <= 1'b0;
      frame_err_cnt <= err_next;
      case (state_q)
        StHdr: begin
          if (rx_ev && rx_data == HDR_BYTE) state_q <= StCmd;
        end
        StCmd: begin
          if (rx_ev) begin
            cmd_q   <= rx_data;
            state_q <= StArg;
          end else if (timeout) begin
            state_q <= StHdr;
          end
        end
        StArg: begin
          if (rx_ev) begin
            arg_q   <= rx_data;
            state_q <= StSum;
          end else if (timeout) begin
            state_q <= StHdr;
          end
        end
        StSum: begin
          if (rx_ev) begin
            sum_q   <= rx_data;
            state_q <= StExec;
          end else if (timeout) begin
            state_q <= StHdr;
          end
        end
        StExec: begin
          led     <= exec_led;
          tx_data <= exec_resp;
          if (exec_ack) frame_ok_cnt <= frame_ok_cnt + 8'd1;
          state_q <= StResp;
        end
        StResp: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state_q  <= StHdr;
          end
        end
        default: state_q <= StHdr;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frames from the test plan followed by
// randomized frames, compared every cycle against a byte/frame-level reference model.
module tb_uart_cmd_decoder;

  localparam int unsigned ToCyc = 100;
  localparam logic [7:0]  Hdr   = 8'hA5;

  logic       clk_50m = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [5:0] led;
  logic [7:0] frame_ok_cnt;
  logic [7:0] frame_err_cnt;

  uart_cmd_decoder #(.TIMEOUT_CYC(ToCyc)) dut (
    .clk_50m      (clk_50m),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .led          (led),
    .frame_ok_cnt (frame_ok_cnt),
    .frame_err_cnt(frame_err_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_cyc = 0;
  logic [5:0] m_led;
  logic [7:0] m_txd, m_ok, m_err;
  logic       m_start;
  logic       m_prev;
  logic       m_exec_pend, m_resp_pend;
  logic [7:0] m_fb[$];
  logic [7:0] m_c, m_a, m_s;
  int         m_last_ev = 0;
  int         m_sum_cyc = 0;
  logic       ev, do_exec, busy, ok;
  logic [7:0] resp;

  // Monitor state
  int   n_starts   = 0;
  int   start_cyc  = 0;
  int   fall_cyc   = 0;
  int   start_fall = 0;
  logic prev_busy  = 1'b0;

  // TX emulation
  int force_cnt = 0;
  int busy_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Reference model: byte queue per frame, response owed until the transmitter is free.
  always @(posedge clk_50m) begin
    m_cyc++;
    m_start = 1'b0;
    if (reset) begin
      m_led = '0; m_txd = '0; m_ok = '0; m_err = '0;
      m_prev = 1'b0; m_exec_pend = 1'b0; m_resp_pend = 1'b0;
      m_fb.delete();
    end else begin
      ev          = rx_done && !m_prev;
      m_prev      = rx_done;
      do_exec     = m_exec_pend;
      m_exec_pend = 1'b0;
      busy        = do_exec || m_resp_pend;
      if (ev) begin
        m_last_ev = m_cyc;
        if (busy) begin
          m_err = sat_inc(m_err);
        end else if (m_fb.size() == 0) begin
          if (rx_data == Hdr) m_fb.push_back(rx_data);
        end else begin
          m_fb.push_back(rx_data);
          if (m_fb.size() == 4) begin
            m_c = m_fb[1]; m_a = m_fb[2]; m_s = m_fb[3];
            m_fb.delete();
            m_exec_pend = 1'b1;
            m_sum_cyc   = m_cyc;
          end
        end
      end
`ifdef UART_CMD_TIMEOUT_EN
      else if (m_fb.size() > 0 && (m_cyc - m_last_ev) == int'(ToCyc)) begin
        m_fb.delete();
        m_err = sat_inc(m_err);
      end
`endif
      if (do_exec) begin
        ok   = 1'b0;
        resp = 8'hEE;
        if (m_s == (m_c ^ m_a)) begin
          if (m_c == 8'h01 && m_a <= 8'd5) begin
            m_led[m_a[2:0]] = ~m_led[m_a[2:0]];
            resp = 8'h5A; ok = 1'b1;
          end else if (m_c == 8'h02) begin
            m_led = m_a[5:0];
            resp = 8'h5A; ok = 1'b1;
          end else if (m_c == 8'h03) begin
            resp = {2'b00, m_led}; ok = 1'b1;
          end
        end
        m_txd = resp;
        if (ok) m_ok = m_ok + 8'd1;
        else    m_err = sat_inc(m_err);
        m_resp_pend = 1'b1;
      end else if (m_resp_pend && !tx_busy) begin
        m_start     = 1'b1;
        m_resp_pend = 1'b0;
      end
    end
  end

  // Per-cycle compare, sampled after the model has settled on this edge.
  always @(posedge clk_50m) begin
    #3;
    chk("led",           32'(led),           32'(m_led));
    chk("tx_data",       32'(tx_data),       32'(m_txd));
    chk("tx_start",      32'(tx_start),      32'(m_start));
    chk("frame_ok_cnt",  32'(frame_ok_cnt),  32'(m_ok));
    chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_err));
    if (tx_start === 1'b1) chk("start_while_busy", 32'(tx_busy), 32'd0);
    if (prev_busy && !tx_busy) fall_cyc = m_cyc;
    prev_busy = tx_busy;
    if (tx_start === 1'b1) begin
      n_starts++;
      start_cyc  = m_cyc;
      start_fall = fall_cyc;
    end
  end

  always @(negedge clk_50m) begin
    if (tx_start === 1'b1 && force_cnt == 0) busy_cnt = $urandom_range(0, 6);
    if (force_cnt > 0) begin
      tx_busy = 1'b1;
      force_cnt--;
    end else if (busy_cnt > 0) begin
      tx_busy = 1'b1;
      busy_cnt--;
    end else begin
      tx_busy = 1'b0;
    end
  end

  initial begin
    repeat (60000) @(posedge clk_50m);
    $display("FAIL watchdog: run exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk_50m);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) @(negedge clk_50m);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s,
                            input int hold);
    send_byte(Hdr, hold, 1);
    send_byte(c, hold, 1);
    send_byte(a, hold, 1);
    send_byte(s, hold, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_exec_pend || m_resp_pend || tx_busy || force_cnt != 0) && n < 4000) begin
      @(negedge clk_50m);
      n++;
    end
    chk("idle_reached", 32'(n < 4000), 32'd1);
    repeat (2) @(negedge clk_50m);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_50m);
    reset = 1'b0;
  endtask

  int         s0;
  int         sel;
  int         h;
  int         n;
  logic [7:0] c, a, s;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk_50m);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_ok", 32'(frame_ok_cnt), 32'd0);
    chk("rst_err", 32'(frame_err_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk_50m);

    // Write 2A
    s0 = n_starts;
    send_frame(8'h02, 8'h2A, 8'h28, 1);
    wait_idle();
    chk("f1_led", 32'(led), 32'h2A);
    chk("f1_model_led", 32'(m_led), 32'h2A);
    chk("f1_tx_data", 32'(tx_data), 32'h5A);
    chk("f1_ok", 32'(frame_ok_cnt), 32'd1);
    chk("f1_starts", 32'(n_starts - s0), 32'd1);
    chk("f1_start_latency", 32'(start_cyc - m_sum_cyc), 32'd2);

    // Toggle bit 0, then read back
    send_frame(8'h01, 8'h00, 8'h01, 1);
    wait_idle();
    chk("tog_tx_data", 32'(tx_data), 32'h5A);
    send_frame(8'h03, 8'h00, 8'h03, 1);
    wait_idle();
    chk("rd_tx_data", 32'(tx_data), 32'h2B);
    chk("rd_led", 32'(led), 32'h2B);
    chk("rd_ok", 32'(frame_ok_cnt), 32'd3);

    // Out-of-range toggle and bad checksum
    send_frame(8'h01, 8'h06, 8'h07, 1);
    wait_idle();
    chk("nak1_tx_data", 32'(tx_data), 32'hEE);
    send_frame(8'h02, 8'h11, 8'h00, 1);
    wait_idle();
    chk("nak2_tx_data", 32'(tx_data), 32'hEE);
    chk("nak_led", 32'(led), 32'h2B);
    chk("nak_err", 32'(frame_err_cnt), 32'd2);
    chk("nak_model_err", 32'(m_err), 32'd2);

    // Garbage, then a frame whose response is held off by a long tx_busy
    send_byte(8'h00, 1, 1);
    send_byte(8'hFF, 1, 1);
    send_byte(8'h13, 1, 1);
    s0 = n_starts;
    force_cnt = 1000;
    send_frame(8'h02, 8'h3F, 8'h3D, 1);
    n = 0;
    while (force_cnt != 0 && n < 1100) begin
      @(negedge clk_50m);
      n++;
    end
    chk("busy_hold_no_start", 32'(n_starts - s0), 32'd0);
    wait_idle();
    chk("busy_starts", 32'(n_starts - s0), 32'd1);
    chk("busy_start_after_fall", 32'(start_cyc - start_fall), 32'd0);
    chk("busy_led", 32'(led), 32'h3F);
    chk("garbage_err", 32'(frame_err_cnt), 32'd2);
    chk("garbage_ok", 32'(frame_ok_cnt), 32'd4);

    // Long rx_done level per byte
    send_frame(8'h02, 8'h15, 8'h17, 20);
    wait_idle();
    chk("long_led", 32'(led), 32'h15);
    chk("long_ok", 32'(frame_ok_cnt), 32'd5);

    // Reset mid-frame
    send_byte(Hdr, 1, 1);
    send_byte(8'h02, 1, 1);
    s0 = n_starts;
    do_reset();
    repeat (5) @(negedge clk_50m);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_ok", 32'(frame_ok_cnt), 32'd0);
    chk("mid_rst_err", 32'(frame_err_cnt), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_starts", 32'(n_starts - s0), 32'd0);

`ifdef UART_CMD_TIMEOUT_EN
    s0 = n_starts;
    send_byte(Hdr, 1, 1);
    send_byte(8'h02, 1, 1);
    repeat (110) @(negedge clk_50m);
    chk("to_err", 32'(frame_err_cnt), 32'd1);
    chk("to_model_err", 32'(m_err), 32'd1);
    chk("to_starts", 32'(n_starts - s0), 32'd0);
    send_frame(8'h02, 8'h01, 8'h03, 1);
    wait_idle();
    chk("to_led", 32'(led), 32'h01);
`endif

    // Randomized frames: mixed commands, bad sums, garbage, dropped bytes, rare resets
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      c = 8'h01;
      else if (sel < 6) c = 8'h02;
      else if (sel < 8) c = 8'h03;
      else              c = 8'($urandom);
      a = (c == 8'h01) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      s = c ^ a;
      if ($urandom_range(0, 9) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
      h = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) send_byte(8'($urandom), 1, $urandom_range(1, 3));
      send_byte(Hdr, h, $urandom_range(1, 3));
      send_byte(c, h, $urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) do_reset();
      send_byte(a, h, $urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) begin
        send_byte(s, 1, 1);
        send_byte(8'($urandom), 1, 1);
      end else begin
        send_byte(s, h, $urandom_range(1, 3));
      end
      if ($urandom_range(0, 3) != 0) wait_idle();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
